// File: rtl/dp_dmi_ctrl.sv
// rtl/dp_dmi_ctrl.sv - DMI request sequencer: turns DMI register updates into single bus transactions
// with timeout and sticky status.
module dp_dmi_ctrl #(
    parameter int ABITS   = 7,
    parameter int TIMEOUT = 255
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic             dmi_upd,
    input  logic [ABITS-1:0] dmi_addr,
    input  logic [31:0]      dmi_data,
    input  logic [1:0]       dmi_op,
    input  logic             dmi_reset,
    input  logic             dmi_hardreset,
    output logic             dm_req,
    output logic             dm_we,
    output logic [ABITS-1:0] dm_addr,
    output logic [31:0]      dm_wdata,
    input  logic             dm_ack,
    input  logic [31:0]      dm_rdata,
    output logic [31:0]      resp_data,
    output logic [1:0]       resp_op,
    output logic             busy
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] tcnt;
    logic [1:0]    sticky;
    logic [1:0]    sticky_eff;
    logic [1:0]    sticky_nxt;
    logic          start;
    logic          acked;
    logic          expired;
    logic          overlap;
    logic          clr;

    assign clr = ireset | dmi_hardreset;

    // A dmi_reset in the same cycle as dmi_upd clears status before the request is judged.
    always_comb begin
        sticky_eff = dmi_reset ? 2'd0 : sticky;
        start      = (state == S_IDLE) && dmi_upd
                     && (dmi_op == 2'd1 || dmi_op == 2'd2) && (sticky_eff == 2'd0);
        acked      = (state == S_REQ) && dm_ack;
        expired    = (state == S_REQ) && !dm_ack && (tcnt == TLAST);
        overlap    = dmi_upd && (state != S_IDLE);
        sticky_nxt = sticky_eff;
        if (sticky_eff == 2'd0) begin
            if (overlap)
                sticky_nxt = 2'd3;
            else if (expired)
                sticky_nxt = 2'd2;
        end
    end

    always_ff @(posedge iclk) begin
        if (clr)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_REQ;
            S_REQ: begin
                if (acked)
                    state_nxt = S_DONE;
                else if (expired)
                    state_nxt = S_IDLE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dm_req  = (state == S_REQ);
        busy    = (state != S_IDLE);
        resp_op = sticky;
    end

    // Hard reset behaves like ireset but keeps the last captured read data.
    always_ff @(posedge iclk) begin
        if (clr) begin
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            sticky   <= 2'd0;
            tcnt     <= '0;
            if (ireset)
                resp_data <= '0;
        end else begin
            sticky <= sticky_nxt;
            if (start) begin
                dm_addr  <= dmi_addr;
                dm_wdata <= dmi_data;
                dm_we    <= (dmi_op == 2'd2);
                tcnt     <= '0;
            end else if (state == S_REQ && !dm_ack) begin
                tcnt <= tcnt + CW'(1);
            end
            if (acked && !dm_we)
                resp_data <= dm_rdata;
        end
    end

endmodule

// File: tb/tb_dp_dmi_ctrl.sv
// tb/tb_dp_dmi_ctrl.sv - scoreboard bench for dp_dmi_ctrl: expected bus requests and completions
// queued by stimulus, checked by a monitor.
module tb_dp_dmi_ctrl;

    logic        iclk = 1'b0;
    logic        ireset = 1'b1;
    logic        dmi_upd = 1'b0;
    logic [6:0]  dmi_addr = '0;
    logic [31:0] dmi_data = '0;
    logic [1:0]  dmi_op = '0;
    logic        dmi_reset = 1'b0;
    logic        dmi_hardreset = 1'b0;
    logic        dm_req;
    logic        dm_we;
    logic [6:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic [31:0] resp_data;
    logic [1:0]  resp_op;
    logic        busy;

    always #5 iclk = ~iclk;

    dp_dmi_ctrl #(.ABITS(7), .TIMEOUT(8)) dut (
        .iclk(iclk), .ireset(ireset), .dmi_upd(dmi_upd), .dmi_addr(dmi_addr),
        .dmi_data(dmi_data), .dmi_op(dmi_op), .dmi_reset(dmi_reset),
        .dmi_hardreset(dmi_hardreset), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .resp_data(resp_data), .resp_op(resp_op), .busy(busy)
    );

    typedef struct {
        bit          is_end;
        logic        we;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  op;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_txn(input logic we, input logic [6:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic [1:0] op, input int len);
        exp_t e;
        e = '{is_end: 1'b0, we: we, addr: addr, wdata: wdata, rdata: '0, op: '0, len: 0};
        exp_q.push_back(e);
        e = '{is_end: 1'b1, we: 1'b0, addr: '0, wdata: '0, rdata: rdata, op: op, len: len};
        exp_q.push_back(e);
    endtask

    task automatic drive_upd(input logic [1:0] op, input logic [6:0] addr,
                             input logic [31:0] data, input logic rst);
        @(negedge iclk);
        dmi_upd = 1'b1; dmi_op = op; dmi_addr = addr; dmi_data = data; dmi_reset = rst;
        @(negedge iclk);
        dmi_upd = 1'b0; dmi_op = 2'd0; dmi_reset = 1'b0;
    endtask

    // Called in the first dm_req cycle; dm_req stays high for n cycles in total.
    task automatic ack_after(input int n, input logic [31:0] rd);
        repeat (n - 1) @(negedge iclk);
        dm_ack = 1'b1; dm_rdata = rd;
        @(negedge iclk);
        dm_ack = 1'b0; dm_rdata = '0;
        check("busy_in_done", busy, 1);
        @(negedge iclk);
        check("busy_fall", busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"}, dm_req, 0);
        check({tag, "_we"}, dm_we, 0);
        check({tag, "_addr"}, dm_addr, 0);
        check({tag, "_wdata"}, dm_wdata, 0);
        check({tag, "_rdata"}, resp_data, 0);
        check({tag, "_op"}, resp_op, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: a dm_req rise pops a request entry, a busy fall pops a completion entry.
    initial begin
        exp_t        e;
        int          len;
        logic        prev_req;
        logic        prev_busy;
        logic [39:0] held;
        len = 0; prev_req = 1'b0; prev_busy = 1'b0; held = '0;
        forever begin
            @(negedge iclk);
            if (dm_req && !prev_req) begin
                len  = 0;
                held = {dm_we, dm_addr, dm_wdata};
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_req: got addr 0x%02h we %0b, expected none", dm_addr, dm_we);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_end || dm_we !== e.we || dm_addr !== e.addr || dm_wdata !== e.wdata) begin
                        nerr++;
                        $display("FAIL bus_req: got we %0b addr 0x%02h wdata 0x%08h, expected end %0b we %0b addr 0x%02h wdata 0x%08h",
                                 dm_we, dm_addr, dm_wdata, e.is_end, e.we, e.addr, e.wdata);
                    end
                end
            end else if (dm_req && prev_req) begin
                nvec++;
                if ({dm_we, dm_addr, dm_wdata} !== held) begin
                    nerr++;
                    $display("FAIL req_stable: got 0x%010h expected 0x%010h", {dm_we, dm_addr, dm_wdata}, held);
                end
            end
            if (dm_req) len++;
            if (!busy && prev_busy) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_end: got resp_op %0d, expected none", resp_op);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_end || resp_data !== e.rdata || resp_op !== e.op || len != e.len) begin
                        nerr++;
                        $display("FAIL txn_end: got rdata 0x%08h op %0d len %0d, expected end %0b rdata 0x%08h op %0d len %0d",
                                 resp_data, resp_op, len, e.is_end, e.rdata, e.op, e.len);
                    end
                end
            end
            prev_req  = dm_req;
            prev_busy = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge iclk);
        check_zero("reset");
        ireset = 1'b0;

        // read, ack on third request cycle
        push_txn(1'b0, 7'h10, 32'h0, 32'hDEADBEEF, 2'd0, 3);
        drive_upd(2'd1, 7'h10, 32'h0, 1'b0);
        check("rd_latency", dm_req, 1);
        ack_after(3, 32'hDEADBEEF);
        check("rd_op", resp_op, 0);

        // write, ack on first request cycle; resp_data untouched
        push_txn(1'b1, 7'h04, 32'h12345678, 32'hDEADBEEF, 2'd0, 1);
        drive_upd(2'd2, 7'h04, 32'h12345678, 1'b0);
        check("wr_latency", dm_req, 1);
        check("wr_we", dm_we, 1);
        ack_after(1, 32'hFFFF0000);

        // timeout after 8 request cycles
        push_txn(1'b0, 7'h20, 32'h0, 32'hDEADBEEF, 2'd2, 8);
        drive_upd(2'd1, 7'h20, 32'h0, 1'b0);
        for (int i = 0; i < 20 && busy; i++) @(negedge iclk);
        check("to_idle", busy, 0);
        check("to_op", resp_op, 2);

        // suppressed while status is sticky
        drive_upd(2'd1, 7'h30, 32'h0, 1'b0);
        check("supp_req", dm_req, 0);
        repeat (2) @(negedge iclk);
        check("supp_req_late", dm_req, 0);
        check("supp_op", resp_op, 2);
        @(negedge iclk); dmi_reset = 1'b1;
        @(negedge iclk); dmi_reset = 1'b0;
        check("clr_op", resp_op, 0);
        push_txn(1'b0, 7'h30, 32'h0, 32'hCAFEF00D, 2'd0, 2);
        drive_upd(2'd1, 7'h30, 32'h0, 1'b0);
        check("retry_latency", dm_req, 1);
        ack_after(2, 32'hCAFEF00D);

        // overlapping update during REQ
        push_txn(1'b0, 7'h11, 32'h0, 32'h0BADF00D, 2'd3, 3);
        drive_upd(2'd1, 7'h11, 32'h0, 1'b0);
        dmi_upd = 1'b1; dmi_op = 2'd2; dmi_addr = 7'h22; dmi_data = 32'h55;
        @(negedge iclk);
        dmi_upd = 1'b0; dmi_op = 2'd0;
        check("ovl_op", resp_op, 3);
        ack_after(2, 32'h0BADF00D);

        // nop keeps a non-zero status as is
        drive_upd(2'd0, 7'h05, 32'h0, 1'b0);
        check("nop_req", dm_req, 0);
        check("nop_op", resp_op, 3);

        // dmi_reset together with dmi_upd: request accepted
        push_txn(1'b0, 7'h12, 32'h0, 32'h13572468, 2'd0, 1);
        drive_upd(2'd1, 7'h12, 32'h0, 1'b1);
        check("clrupd_latency", dm_req, 1);
        ack_after(1, 32'h13572468);

        // hard reset mid-REQ keeps resp_data
        push_txn(1'b0, 7'h01, 32'h0, 32'h13572468, 2'd0, 1);
        drive_upd(2'd1, 7'h01, 32'h0, 1'b0);
        dmi_hardreset = 1'b1;
        @(negedge iclk);
        dmi_hardreset = 1'b0;
        check("hr_req", dm_req, 0);
        check("hr_rdata", resp_data, 32'h13572468);

        // ireset mid-REQ, late ack ignored
        push_txn(1'b1, 7'h7F, 32'hA5A5A5A5, 32'h0, 2'd0, 2);
        drive_upd(2'd2, 7'h7F, 32'hA5A5A5A5, 1'b0);
        check("rst_latency", dm_req, 1);
        @(negedge iclk); ireset = 1'b1;
        @(negedge iclk); ireset = 1'b0;
        check_zero("midrst");
        dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
        @(negedge iclk); dm_ack = 1'b0; dm_rdata = '0;
        repeat (2) @(negedge iclk);
        check_zero("lateack");

        // reserved opcode
        drive_upd(2'd3, 7'h05, 32'h0, 1'b0);
        check("rsv_req", dm_req, 0);
        check("rsv_busy", busy, 0);

        repeat (3) @(negedge iclk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dp_dmi_ctrl.md
DP_DMI_CTRL -- requirements
Module: dp_dmi_ctrl

Parameters
REQ-001 SHALL have parameters, one per line:
- ABITS, 7, DMI address width.
- TIMEOUT, 255, maximum wait cycles for dm_ack before failing.

Interface
REQ-002 SHALL have the following ports, one per line (name, direction, width, meaning):
- iclk, in, 1, internal clock.
- ireset, in, 1, reset; synchronous, active-high.
- dmi_upd, in, 1, one-cycle pulse: DMI register updated.
- dmi_addr, in, ABITS, request address.
- dmi_data, in, 32, request write data.
- dmi_op, in, 2, request opcode: 0 nop, 1 read, 2 write, 3 reserved.
- dmi_reset, in, 1, pulse from DTMCS: clear sticky status.
- dmi_hardreset, in, 1, pulse: abort the transaction and clear status.
- dm_req, out, 1, bus request.
- dm_we, out, 1, write enable.
- dm_addr, out, ABITS, bus address.
- dm_wdata, out, 32, bus write data.
- dm_ack, in, 1, bus acknowledge.
- dm_rdata, in, 32, bus read data, valid with dm_ack.
- resp_data, out, 32, captured read data, fed to the DMI register parallel input.
- resp_op, out, 2, status: 0 ok, 2 failed, 3 busy.
- busy, out, 1, transaction in flight.

Function
REQ-003 SHALL implement an FSM with states IDLE, REQ and DONE.
REQ-004 IDLE, dmi_upd=1, dmi_op in {1,2}, sticky status=0: SHALL latch dm_addr and dm_wdata, set dm_we=(op==2), assert dm_req on the next cycle, and go to REQ.
REQ-005 IDLE, dmi_upd=1, with dmi_op 0 or 3 or sticky status!=0: SHALL issue no bus request and leave resp_op unchanged.
REQ-006 REQ: dm_req, dm_we, dm_addr and dm_wdata SHALL stay stable until the cycle in which dm_ack=1.
REQ-007 REQ, dm_ack=1: dm_req SHALL fall the next cycle; a read SHALL capture dm_rdata into resp_data; the FSM SHALL go to DONE.
REQ-008 DONE: SHALL return to IDLE after exactly one cycle; a write SHALL leave resp_data unchanged.
REQ-009 Timeout counter:
- Cleared on entry to REQ; increments each REQ cycle without dm_ack.
- On reaching TIMEOUT: dm_req drops, sticky status=2, FSM goes to IDLE.
- A dm_ack arriving in the timeout cycle SHALL win; no error is flagged.
REQ-010 dmi_upd while the FSM is not IDLE: SHALL set sticky status=3, ignore the request, and leave the ongoing transaction undisturbed.
REQ-011 Sticky status SHALL drive resp_op; once non-zero it SHALL hold until dmi_reset, dmi_hardreset or ireset.
- Busy (3) SHALL override a simultaneous failed (2).
REQ-012 dmi_reset SHALL clear the sticky status only; it SHALL NOT affect the FSM.
- dmi_reset and dmi_upd in the same cycle: the clear SHALL take effect first, then the request SHALL be evaluated against a clear status.
REQ-013 dmi_hardreset SHALL act as ireset except that resp_data SHALL be retained.
REQ-014 busy SHALL be 1 in REQ and DONE, and 0 in IDLE.
REQ-015 Overall latency: dm_req SHALL rise 1 cycle after dmi_upd; busy SHALL fall 2 cycles after dm_ack.

Reset
REQ-016 ireset=1 SHALL force state IDLE and set dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, resp_data=0, resp_op=0, busy=0, timeout counter=0.
REQ-017 Reset asserted mid-transaction SHALL drop dm_req on the next edge; a dm_ack arriving later SHALL be ignored.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Read: op=1, addr=0x10, ack after 3 cycles with rdata=0xDEADBEEF -> resp_data=0xDEADBEEF, resp_op=0, one dm_req pulse train.
- Write: op=2, addr=0x04, data=0x12345678, ack after 1 cycle -> dm_we=1, dm_wdata=0x12345678, resp_op=0.
- Timeout: TIMEOUT=8, no ack -> dm_req low after 8 cycles, resp_op=2; the next read is suppressed until a dmi_reset pulse, after which the read succeeds.
- Overlap: second dmi_upd during REQ -> resp_op=3, first transaction completes normally, no second dm_req.
- Reset mid-REQ: ireset for 1 cycle -> all outputs 0; a later dm_ack causes no change.
- Nop: op=0 -> dm_req stays 0, resp_op unchanged.
